// File: rtl/mips_pkg.sv
// Shared MIPS-system definitions: imem geometry and the loader state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mips_pkg;

   localparam int IMEM_DEPTH  = 64;
   localparam int IMEM_ADDR_W = 6;

   // Loader FSM encoding. CSUM is only reachable when the checksum build option
   // is enabled, but it keeps its code so both builds share one encoding.
   typedef enum logic [2:0] {
      HDR_HI = 3'd0,
      HDR_LO = 3'd1,
      DATA   = 3'd2,
      WRITE  = 3'd3,
      CSUM   = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } loader_state_e;

endpackage

// File: rtl/imem_word_pack.sv
// Packs a byte stream into 32-bit words, first byte ends up in word[31:24].
// Latency: word updates on the edge after shift; last flags the 4th byte of a word.
// Backpressure: none; the caller only pulses shift on accepted bytes.
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   shift       shift din into the word this cycle
//   din[7:0]    byte to shift in
//   word[31:0]  assembled word (shift register contents)
//   last        current byte index is 3, i.e. this shift completes a word
module imem_word_pack (
   input  logic        clk,
   input  logic        reset,
   input  logic        shift,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        last
);

   logic [1:0] idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word <= 32'd0;
         idx  <= 2'd0;
      end else if (shift) begin
         word <= {word[23:0], din};
         // Wraps 3 -> 0 naturally, so a completed word leaves the index ready
         // for the next one.
         idx  <= idx + 2'd1;
      end
   end

   assign last = (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes WCNT header + WCNT big-endian words over valid/ready,
// writes them to consecutive imem words, then releases the CPU from reset.
// Latency: imem_we one cycle after a word's 4th byte; 5 cycles/word minimum.
// Backpressure: in_ready is a pure state decode, low in WRITE/DONE/ERROR.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   in_valid/in_data      byte source, transfer = in_valid & in_ready
//   in_ready              loader accepts a byte this cycle
//   imem_we/addr/wdata    registered single-cycle imem write
//   cpu_reset             1 holds the CPU in reset until the load is done
//   done / error          sticky load-complete / load-rejected flags
//
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing mod-256 payload
// checksum byte that must match before done is raised.
module imem_loader
   import mips_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   loader_state_e     state, state_n;
   logic [15:0]       cnt;
   logic [15:0]       hdr_cnt;
   logic [ADDR_W-1:0] widx;
   logic              xfer;
   logic              shift;
   logic              last_byte;
   logic              last_word;
   logic              accepting;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        sum;
`endif

   imem_word_pack u_pack (
      .clk   (clk),
      .reset (reset),
      .shift (shift),
      .din   (in_data),
      .word  (imem_wdata),
      .last  (last_byte)
   );

   always_comb begin
      accepting = 1'b0;
      case (state)
         HDR_HI, HDR_LO, DATA: accepting = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:                 accepting = 1'b1;
`endif
         default:              accepting = 1'b0;
      endcase
   end

   // Gated with reset so the port reads 0 while reset is held, even though
   // the state register already sits in HDR_HI.
   assign in_ready  = accepting & ~reset;
   assign xfer      = in_valid & in_ready;
   assign shift     = xfer & (state == DATA);
   assign hdr_cnt   = {cnt[15:8], in_data};
   assign last_word = ({{(16-ADDR_W){1'b0}}, widx} == (cnt - 16'd1));

   always_comb begin
      state_n = state;
      case (state)
         HDR_HI: if (xfer) state_n = HDR_LO;
         HDR_LO: begin
            if (xfer) begin
               if (hdr_cnt > DEPTH_W)
                  state_n = ERROR;
               else if (hdr_cnt == 16'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_n = CSUM;
`else
                  state_n = DONE;
`endif
               else
                  state_n = DATA;
            end
         end
         DATA:   if (xfer && last_byte) state_n = WRITE;
         WRITE: begin
            if (last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_n = CSUM;
`else
               state_n = DONE;
`endif
            else
               state_n = DATA;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:   if (xfer) state_n = (in_data == sum) ? DONE : ERROR;
`endif
         DONE:   state_n = DONE;
         ERROR:  state_n = ERROR;
         default: state_n = HDR_HI;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= HDR_HI;
      end else begin
         state <= state_n;
      end
   end

   // Output flags are registered from the next state so they line up with the
   // state they describe, without a combinational path from in_valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_we   <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         cpu_reset <= 1'b1;
      end else begin
         imem_we   <= (state_n == WRITE);
         done      <= (state_n == DONE);
         error     <= (state_n == ERROR);
         cpu_reset <= (state_n != DONE);
      end
   end

   // widx doubles as imem_addr: it holds the current word's index throughout
   // WRITE and advances as WRITE is left.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= 16'd0;
         widx <= '0;
      end else begin
         if (xfer && state == HDR_HI) cnt[15:8] <= in_data;
         if (xfer && state == HDR_LO) cnt[7:0]  <= in_data;
         if (state == WRITE)          widx      <= widx + 1'b1;
      end
   end

   assign imem_addr = widx;

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum <= 8'd0;
      end else if (state == HDR_HI) begin
         sum <= 8'd0;
      end else if (shift) begin
         sum <= sum + in_data;
      end
   end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, oversize header, empty load,
// gapped stream, mid-load reset and (optionally) trailing checksum byte.
// Writes are captured by a negedge monitor and compared to hand-computed words.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Write / done monitor
   logic [5:0]  wr_addr [4];
   logic [31:0] wr_data [4];
   int          wr_cyc  [4];
   int          n_wr = 0;
   logic        done_seen = 1'b0;
   int          done_cyc = 0;
   logic        cpu_at_done = 1'b1;

   // Scenario-1 stream: header 00 02, words 20080005 and 2009000C
   logic [7:0] s1 [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                           8'h20, 8'h09, 8'h00, 8'h0C};

   imem_loader dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (imem_we) begin
         if (n_wr < 4) begin
            wr_addr[n_wr] = imem_addr;
            wr_data[n_wr] = imem_wdata;
            wr_cyc[n_wr]  = cyc;
         end
         n_wr++;
      end
      if (done && !done_seen) begin
         done_seen   = 1'b1;
         done_cyc    = cyc;
         cpu_at_done = cpu_reset;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic clear_mon();
      n_wr      = 0;
      done_seen = 1'b0;
      done_cyc  = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      clear_mon();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_in_ready"},   in_ready,   1'b0);
      check({pfx, "_imem_we"},    imem_we,    1'b0);
      check({pfx, "_imem_addr"},  imem_addr,  6'd0);
      check({pfx, "_imem_wdata"}, imem_wdata, 32'd0);
      check({pfx, "_cpu_reset"},  cpu_reset,  1'b1);
      check({pfx, "_done"},       done,       1'b0);
      check({pfx, "_error"},      error,      1'b0);
   endtask

   // Offer one byte after 'gap' idle cycles; returns after the accepting edge.
   task automatic send(input logic [7:0] b, input int gap);
      int k;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) check("send_ready_timeout", in_ready, 1'b1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_end(input string pfx);
      int k;
      k = 0;
      while (!(done || error) && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (k >= 60) check({pfx, "_end_timeout"}, done | error, 1'b1);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_s1(input int gapped);
      for (int i = 0; i < 10; i++)
         send(s1[i], gapped ? int'($urandom_range(1, 7)) : 0);
   endtask

   task automatic check_s1(input string pfx, input int timing);
      check({pfx, "_n_wr"},  n_wr, 2);
      check({pfx, "_addr0"}, wr_addr[0], 6'd0);
      check({pfx, "_data0"}, wr_data[0], 32'h2008_0005);
      check({pfx, "_addr1"}, wr_addr[1], 6'd1);
      check({pfx, "_data1"}, wr_data[1], 32'h2009_000C);
      check({pfx, "_done"},      done,      1'b1);
      check({pfx, "_error"},     error,     1'b0);
      check({pfx, "_cpu_reset"}, cpu_reset, 1'b0);
      check({pfx, "_cpu_at_done"}, cpu_at_done, 1'b0);
      if (timing != 0) begin
         check({pfx, "_word_spacing"}, wr_cyc[1] - wr_cyc[0], 5);
`ifndef IMEM_LOADER_CHECKSUM_EN
         check({pfx, "_done_cycle"}, done_cyc, wr_cyc[1] + 1);
`endif
      end
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check_reset_vals("rst");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("hdr_hi_ready", in_ready, 1'b1);

      // 1: two words, in_valid held high
      clear_mon();
      run_s1(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Payload sum 20+08+00+05+20+09+00+0C = 0x62
      send(8'h62, 0);
`endif
      idle();
      wait_end("s1");
      check_s1("s1", 1);
      // Sticky DONE ignores further bytes
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (3) @(negedge clk);
      check("s1_done_ready", in_ready, 1'b0);
      check("s1_done_sticky", done, 1'b1);
      check("s1_no_extra_we", n_wr, 2);
      in_valid = 1'b0;

      // 2: oversize header 00 41
      apply_reset();
      send(8'h00, 0);
      send(8'h41, 0);
      @(negedge clk);
      check("s2_error", error, 1'b1);
      check("s2_in_ready", in_ready, 1'b0);
      check("s2_cpu_reset", cpu_reset, 1'b1);
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      check("s2_no_we", n_wr, 0);
      check("s2_error_sticky", error, 1'b1);
      check("s2_done", done, 1'b0);

      // 3: empty program
      apply_reset();
      send(8'h00, 0);
      send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00, 0);
`endif
      idle();
      wait_end("s3");
      check("s3_done", done, 1'b1);
      check("s3_no_we", n_wr, 0);
      check("s3_cpu_reset", cpu_reset, 1'b0);

      // 4: random 1-7 cycle gaps between bytes
      apply_reset();
      run_s1(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h62, 3);
`endif
      idle();
      wait_end("s4");
      check_s1("s4", 0);

      // 5: reset after 6th byte (during the first write), then replay
      apply_reset();
      for (int i = 0; i < 6; i++) send(s1[i], 0);
      @(negedge clk);
      check("s5_we_before", imem_we, 1'b1);
      #1 reset = 1'b1;
      #1;
      check_reset_vals("s5_rst");
      in_valid = 1'b0;
      clear_mon();
      @(negedge clk);
      reset = 1'b0;
      run_s1(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h62, 0);
`endif
      idle();
      wait_end("s5");
      check_s1("s5", 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // 6: wrong checksum byte
      apply_reset();
      run_s1(0);
      send(8'h63, 0);
      idle();
      wait_end("s6");
      check("s6_error", error, 1'b1);
      check("s6_done", done, 1'b0);
      check("s6_cpu_reset", cpu_reset, 1'b1);
      check("s6_n_wr", n_wr, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
